ibwt_stream: RTL
================

IBWT_STREAM -- requirements
Module: ibwt_stream

Interface
REQ-001 SHALL have parameter MAX_LEN, default 128, meaning maximum frame length in symbols, including the sentinel.
REQ-002 SHALL have parameter CHAR_W, default 8, meaning symbol width in bits.
REQ-003 SHALL have parameter SENTINEL, default 8'h24 ('$'), meaning the terminator symbol.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_char is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a symbol.
REQ-008 SHALL have port in_char  input  CHAR_W  BWT (L-column) symbol.
REQ-009 SHALL have port in_last  input  1  final symbol of the frame.
REQ-010 SHALL have port out_valid  output  1  out_char is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_char  output  CHAR_W  recovered text symbol.
REQ-013 SHALL have port out_last  output  1  final output symbol (the sentinel).
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port error  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, PREFIX, WALK and EMIT.
REQ-017 SHALL define a handshake as valid and ready both high at a rising edge.
REQ-018 SHALL drive in_ready=1 only in IDLE and LOAD, and out_valid=1 only in EMIT.
REQ-019 SHALL move IDLE->LOAD on the first input handshake; that symbol is stored at L[0].
REQ-020 SHALL, on each input handshake k, store L[k] and rank[k] = count[in_char] (the value before increment), then increment count[in_char].
REQ-021 SHALL take the frame length n as the number of handshakes up to and including in_last, with 1 <= n <= MAX_LEN.
REQ-022 SHALL, when the MAX_LEN-th symbol arrives with in_last=0, treat that symbol as last and mark the frame overflowed.
REQ-023 SHALL, at end of LOAD, reject the frame when count[SENTINEL] != 1, when any symbol is numerically below SENTINEL, or when the frame overflowed.
REQ-024 SHALL, for a rejected frame, pulse error for the one cycle after the last-symbol edge, go to IDLE, and produce no output beats.
REQ-025 SHALL, in PREFIX, spend exactly 2^CHAR_W cycles building C[c] = sum of count[s] for s < c, one symbol per cycle.
REQ-026 SHALL, in WALK, start from row r=0 and perform one step per cycle for n-1 cycles.
REQ-027 SHALL, on WALK step j (j=0..n-2), write out_buf[n-2-j] = L[r], then set r = C[L[r]] + rank[r].
REQ-028 SHALL set out_buf[n-1] = SENTINEL.
REQ-029 SHALL skip WALK (zero cycles) when n=1.
REQ-030 SHALL, in EMIT, present out_buf[0..n-1] in order, advancing only on an output handshake.
REQ-031 SHALL assert out_last together with out_buf[n-1].
REQ-032 SHALL hold out_char and out_last stable while out_valid=1 and out_ready=0.
REQ-033 SHALL return to IDLE after the out_last handshake, with count cleared, ready for the next frame with no idle gap required.
REQ-034 SHALL assert the first out_valid exactly 2^CHAR_W + n - 1 rising edges after the in_last handshake edge (excluding out_ready stalls, which apply only in EMIT).
REQ-035 SHALL size row, rank and C values to clog2(MAX_LEN+1) bits; no sum can overflow because it is bounded by n.
REQ-036 SHALL use registers for the L, rank, count, C and out_buf arrays, read combinationally within a cycle.

Reset
REQ-037 SHALL, while rst_n=0, force state=IDLE, every count=0, in_ready=0, out_valid=0, out_char=0, out_last=0, busy=0 and error=0.
REQ-038 SHALL drive in_ready=1 on the first rising edge after rst_n deasserts.
REQ-039 SHALL, on reset asserted in any state including mid-WALK or mid-EMIT, discard the frame and emit no further beats.

Verification
REQ-040 SHALL cover: input "annb$aa" (n=7), out_ready=1 -> output "banana$", out_last on '$', first out_valid 262 edges after the in_last edge.
REQ-041 SHALL cover: input "ipssm$pissii" -> output "mississippi$"; then "$" (n=1) back-to-back -> output "$" with out_last=1.
REQ-042 SHALL cover: input "ab$$" -> error high for exactly one cycle, out_valid never high, next valid frame decodes correctly.
REQ-043 SHALL cover: 128-symbol frame with in_last=0 on every beat -> error pulse; a frame with symbol 8'h20 -> error pulse.
REQ-044 SHALL cover: "annb$aa" with out_ready random 50% and in_valid gaps -> output still "banana$", no drops or duplicates, data held during stalls.
REQ-045 SHALL cover: rst_n pulsed low during WALK -> all outputs 0 immediately, in_ready=1 one edge after release, no stale beats.

Source files
------------

// File: rtl/ibwt_stream.sv
// Streaming inverse Burrows-Wheeler transform: loads one L-column frame, rebuilds
// the text with an LF-mapping walk, then streams it out ending with the sentinel.
module ibwt_stream #(
  parameter int unsigned       MAX_LEN  = 128,
  parameter int unsigned       CHAR_W   = 8,
  parameter logic [CHAR_W-1:0] SENTINEL = 8'h24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_last,
  output logic              busy,
  output logic              error
);
  localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned NSYM   = 1 << CHAR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PREFIX = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CHAR_W-1:0] l_mem    [MAX_LEN];
  logic [IDX_W-1:0]  rank_mem [MAX_LEN];
  logic [CHAR_W-1:0] obuf     [MAX_LEN];
  logic [IDX_W-1:0]  count    [NSYM];
  logic [IDX_W-1:0]  c_mem    [NSYM];

  logic [ADDR_W-1:0] idx_q, wp_q, rd_q, rd_nx;
  logic [IDX_W-1:0]  len_q, acc_q, row_q, next_row, sent_cnt;
  logic [CHAR_W-1:0] pfx_q, lr;
  logic              bad_q, in_hs, out_hs, last_sym, reject;
  logic              in_ready_d, out_valid_d, busy_d, error_d, out_last_d;
  logic [CHAR_W-1:0] out_char_d;

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  // A full buffer forces end-of-frame; reject is only consulted on that last beat.
  assign last_sym = in_last || (idx_q == ADDR_W'(MAX_LEN - 1));
  assign sent_cnt = count[SENTINEL] + IDX_W'(in_char == SENTINEL);
  assign reject   = (sent_cnt != IDX_W'(1)) || bad_q || (in_char < SENTINEL) || !in_last;
  assign lr       = l_mem[ADDR_W'(row_q)];
  assign next_row = c_mem[lr] + rank_mem[ADDR_W'(row_q)];
  assign rd_nx    = rd_q + ADDR_W'(1);

  // Next state and next registered output values.
  always_comb begin
    state_d    = state_q;
    error_d    = 1'b0;
    out_char_d = out_char;
    out_last_d = out_last;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_hs) begin
          if (!last_sym) begin
            state_d = S_LOAD;
          end else if (reject) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else begin
            state_d = S_PREFIX;
          end
        end
      end
      S_PREFIX: begin
        if (pfx_q == CHAR_W'(NSYM - 1)) begin
          if (len_q == IDX_W'(1)) begin
            state_d    = S_EMIT;
            out_char_d = SENTINEL;
            out_last_d = 1'b1;
          end else begin
            state_d = S_WALK;
          end
        end
      end
      S_WALK: begin
        if (wp_q == '0) begin
          state_d    = S_EMIT;
          out_char_d = lr;
          out_last_d = 1'b0;
        end
      end
      S_EMIT: begin
        if (out_hs) begin
          if (out_last) begin
            state_d    = S_IDLE;
            out_char_d = '0;
            out_last_d = 1'b0;
          end else begin
            out_char_d = obuf[rd_nx];
            out_last_d = (IDX_W'(rd_nx) == len_q - IDX_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    out_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_char  <= out_char_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      error     <= error_d;
    end
  end

  // Counters, histogram and walk pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSYM); i++) count[i] <= '0;
      idx_q <= '0;
      bad_q <= 1'b0;
      len_q <= '0;
      pfx_q <= '0;
      acc_q <= '0;
      row_q <= '0;
      wp_q  <= '0;
      rd_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (in_hs) begin
            if (last_sym) begin
              idx_q <= '0;
              bad_q <= 1'b0;
              len_q <= IDX_W'(idx_q) + IDX_W'(1);
              pfx_q <= '0;
              acc_q <= '0;
              if (reject) begin
                for (int i = 0; i < int'(NSYM); i++) count[i] <= '0;
              end else begin
                count[in_char] <= count[in_char] + IDX_W'(1);
              end
            end else begin
              idx_q          <= idx_q + ADDR_W'(1);
              bad_q          <= bad_q || (in_char < SENTINEL);
              count[in_char] <= count[in_char] + IDX_W'(1);
            end
          end
        end
        S_PREFIX: begin
          pfx_q <= pfx_q + CHAR_W'(1);
          acc_q <= acc_q + count[pfx_q];
          row_q <= '0;
          wp_q  <= ADDR_W'(len_q - IDX_W'(2));
          rd_q  <= '0;
        end
        S_WALK: begin
          row_q <= next_row;
          wp_q  <= wp_q - ADDR_W'(1);
        end
        S_EMIT: begin
          if (out_hs) begin
            rd_q <= rd_nx;
            if (out_last) begin
              for (int i = 0; i < int'(NSYM); i++) count[i] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame storage, prefix table and output buffer.
  always_ff @(posedge clk) begin
    if (((state_q == S_IDLE) || (state_q == S_LOAD)) && in_hs) begin
      l_mem[idx_q]    <= in_char;
      rank_mem[idx_q] <= count[in_char];
      if (last_sym) obuf[idx_q] <= SENTINEL;
    end
    if (state_q == S_PREFIX) c_mem[pfx_q] <= acc_q;
    if (state_q == S_WALK) obuf[wp_q] <= lr;
  end

endmodule
